tile_req_join: RTL and testbench

TILE_REQ_JOIN -- requirements
Module: tile_req_join

---
 rtl/tile_req_join.sv | 166 ++++++++++++++++
 tb/tb_tile_req_join.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_req_join.sv
// tile_req_join: joins NumPorts upstream request channels onto one downstream
// channel with round-robin arbitration, and routes the in-order responses back
// to the originating port via a tracking FIFO of granted port indices.
// Optional feature: define TILE_REQ_JOIN_ISOLATE_EN to add isolate_i/isolated_o.
module tile_req_join #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RspWidth       = 64,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0]                in_req_valid_i,
    output logic [NumPorts-1:0]                in_req_ready_o,
    input  logic [NumPorts-1:0][ReqWidth-1:0]  in_req_data_i,
    output logic                               out_req_valid_o,
    input  logic                               out_req_ready_i,
    output logic [ReqWidth-1:0]                out_req_data_o,
    input  logic                               out_rsp_valid_i,
    output logic                               out_rsp_ready_o,
    input  logic [RspWidth-1:0]                out_rsp_data_i,
    output logic [NumPorts-1:0]                in_rsp_valid_o,
    input  logic [NumPorts-1:0]                in_rsp_ready_i,
    output logic [NumPorts-1:0][RspWidth-1:0]  in_rsp_data_o
`ifdef TILE_REQ_JOIN_ISOLATE_EN
    ,
    input  logic                               isolate_i,
    output logic                               isolated_o
`endif
);

    localparam int unsigned PortW = $clog2(NumPorts);
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    logic [PortW-1:0] prio_q, prio_d;
    logic             lock_q, lock_d;
    logic [PortW-1:0] lock_port_q, lock_port_d;
    logic [PortW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [PortW-1:0] grant;
    logic             found;
    logic             full, empty;
    logic             req_hs, rsp_hs;
    logic [PortW-1:0] head;
    logic             iso_block;

`ifdef TILE_REQ_JOIN_ISOLATE_EN
    assign iso_block = isolate_i;
`else
    assign iso_block = 1'b0;
`endif

    assign full  = (cnt_q == CntW'(MaxOutstanding));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // Grant selection: a locked grant wins; otherwise first valid port from prio_q.
    always_comb begin
        int idx;
        grant = lock_port_q;
        found = lock_q;
        idx   = 0;
        if (!lock_q && !iso_block) begin
            for (int i = 0; i < int'(NumPorts); i++) begin
                idx = int'(prio_q) + i;
                if (idx >= int'(NumPorts)) idx = idx - int'(NumPorts);
                if (!found && in_req_valid_i[idx]) begin
                    found = 1'b1;
                    grant = PortW'(idx);
                end
            end
        end
    end

    // Request path: zero-latency forward of the granted port, gated by FIFO room.
    always_comb begin
        in_req_ready_o  = '0;
        out_req_valid_o = rst_ni && found && in_req_valid_i[grant] && !full;
        out_req_data_o  = in_req_data_i[grant];
        if (rst_ni && found && !full)
            in_req_ready_o[grant] = out_req_ready_i;
    end

    assign req_hs = out_req_valid_o && out_req_ready_i;

    // Response path: the FIFO head owns the response channel.
    always_comb begin
        in_rsp_valid_o = '0;
        if (!empty)
            in_rsp_valid_o[head] = out_rsp_valid_i;
        out_rsp_ready_o = !empty && in_rsp_ready_i[head];
    end

    assign in_rsp_data_o = {NumPorts{out_rsp_data_i}};
    assign rsp_hs        = out_rsp_valid_i && out_rsp_ready_o;

    // Next-state for arbitration pointer, lock and occupancy.
    always_comb begin
        prio_d      = prio_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        cnt_d       = cnt_q;
        if (req_hs) begin
            lock_d = 1'b0;
            prio_d = (grant == PortW'(NumPorts - 1)) ? '0 : grant + 1'b1;
        end else if (out_req_valid_o) begin
            lock_d      = 1'b1;
            lock_port_d = grant;
        end
        if (req_hs && !rsp_hs)
            cnt_d = cnt_q + 1'b1;
        else if (!req_hs && rsp_hs)
            cnt_d = cnt_q - 1'b1;
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= '0;
        end else begin
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end

    // Tracking FIFO of granted ports; pointers wrap at MaxOutstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (req_hs) begin
                fifo_q[wr_ptr_q] <= grant;
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rsp_hs)
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

`ifdef TILE_REQ_JOIN_ISOLATE_EN
    logic isolated_q;

    // Isolated once requested with no lock and nothing left outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) isolated_q <= 1'b0;
        else         isolated_q <= isolate_i && !lock_d && (cnt_d == '0);
    end

    assign isolated_o = isolated_q;
`endif

    // A response with nothing outstanding has no owner.
    rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_rsp_valid_i |-> !empty);

endmodule

// File: tb/tb_tile_req_join.sv
// Directed bench for tile_req_join (NumPorts=3, MaxOutstanding=4) with
// scoreboard queues of expected grants and expected response routing.
module tb_tile_req_join;

    localparam int NP = 3;
    localparam int RW = 16;

    logic               clk;
    logic               rst_n;
    logic [NP-1:0]      in_req_valid;
    logic [NP-1:0]      in_req_ready;
    logic [NP-1:0][RW-1:0] in_req_data;
    logic               out_req_valid;
    logic               out_req_ready;
    logic [RW-1:0]      out_req_data;
    logic               out_rsp_valid;
    logic               out_rsp_ready;
    logic [RW-1:0]      out_rsp_data;
    logic [NP-1:0]      in_rsp_valid;
    logic [NP-1:0]      in_rsp_ready;
    logic [NP-1:0][RW-1:0] in_rsp_data;
`ifdef TILE_REQ_JOIN_ISOLATE_EN
    logic               isolate;
    logic               isolated;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int gq[$];
    int rq[$];
    logic [RW-1:0] dq[$];

    tile_req_join #(
        .NumPorts(NP), .ReqWidth(RW), .RspWidth(RW), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_valid_i(in_req_valid), .in_req_ready_o(in_req_ready),
        .in_req_data_i(in_req_data),
        .out_req_valid_o(out_req_valid), .out_req_ready_i(out_req_ready),
        .out_req_data_o(out_req_data),
        .out_rsp_valid_i(out_rsp_valid), .out_rsp_ready_o(out_rsp_ready),
        .out_rsp_data_i(out_rsp_data),
        .in_rsp_valid_o(in_rsp_valid), .in_rsp_ready_i(in_rsp_ready),
        .in_rsp_data_o(in_rsp_data)
`ifdef TILE_REQ_JOIN_ISOLATE_EN
        , .isolate_i(isolate), .isolated_o(isolated)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected request grant: pops the grant queue, logs routing for the response.
    task automatic expect_grant(input string tag);
        int p;
        p = gq.pop_front();
        chk({tag, "_valid"}, 64'(out_req_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_req_data), 64'(in_req_data[p]));
        chk({tag, "_ready"}, 64'(in_req_ready), 64'(1 << p));
        rq.push_back(p);
    endtask

    // Expected response routing: pops port and data scoreboards.
    task automatic expect_rsp(input string tag);
        int p;
        logic [RW-1:0] d;
        p = rq.pop_front();
        d = dq.pop_front();
        chk({tag, "_rvalid"}, 64'(in_rsp_valid), 64'(1 << p));
        chk({tag, "_rdata"}, 64'(in_rsp_data[p]), 64'(d));
        chk({tag, "_rready"}, 64'(out_rsp_ready), 64'(in_rsp_ready[p]));
    endtask

    task automatic drive_rsp(input logic [RW-1:0] d);
        out_rsp_valid = 1'b1;
        out_rsp_data  = d;
        dq.push_back(d);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_req_valid  = 3'b111;
        for (int p = 0; p < NP; p++) in_req_data[p] = RW'(16'h100 + p);
        out_req_ready = 1'b1;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        in_rsp_ready  = 3'b111;
`ifdef TILE_REQ_JOIN_ISOLATE_EN
        isolate       = 1'b0;
`endif
        #3;
        chk("rst_out_req_valid", 64'(out_req_valid), 64'd0);
        chk("rst_in_req_ready", 64'(in_req_ready), 64'd0);
        chk("rst_out_rsp_ready", 64'(out_rsp_ready), 64'd0);
        chk("rst_in_rsp_valid", 64'(in_rsp_valid), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fairness: all ports valid, downstream always ready, responses one cycle behind.
        in_req_valid = 3'b111;
        gq = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < 6; k++) begin
            if (k > 0) drive_rsp(RW'(16'h200 + k));
            #1;
            if (k > 0) expect_rsp("fair");
            expect_grant("fair");
            tick();
        end
        in_req_valid = '0;
        drive_rsp(RW'(16'h2FF));
        #1;
        expect_rsp("fair_last");
        tick();
        out_rsp_valid = 1'b0;
        #1;
        chk("empty_rsp_ready", 64'(out_rsp_ready), 64'd0);

        // Stability: port 1 locked while port 0 (higher priority now) arrives.
        out_req_ready  = 1'b0;
        in_req_data[1] = RW'(16'h00AA);
        in_req_data[0] = RW'(16'h0055);
        in_req_valid   = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stab_hold_data", 64'(out_req_data), 64'h00AA);
            chk("stab_hold_valid", 64'(out_req_valid), 64'd1);
            tick();
        end
        in_req_valid = 3'b011;
        #1;
        chk("stab_locked_data", 64'(out_req_data), 64'h00AA);
        chk("stab_locked_ready", 64'(in_req_ready), 64'd0);
        tick();
        out_req_ready = 1'b1;
        gq.push_back(1);
        #1;
        expect_grant("stab_p1");
        tick();
        in_req_valid = 3'b001;
        gq.push_back(0);
        #1;
        expect_grant("stab_p0");
        tick();
        in_req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            drive_rsp(RW'(16'h300 + k));
            #1;
            expect_rsp("stab_rsp");
            tick();
        end
        out_rsp_valid = 1'b0;

        // Backpressure: four accepted, fifth stalls until a response handshakes.
        in_req_data[2] = RW'(16'h00CC);
        in_req_valid   = 3'b100;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(2);
            #1;
            expect_grant("bp_fill");
            tick();
        end
        #1;
        chk("bp_full_valid", 64'(out_req_valid), 64'd0);
        chk("bp_full_ready", 64'(in_req_ready), 64'd0);
        tick();
        drive_rsp(RW'(16'h0400));
        #1;
        chk("bp_full_pop_valid", 64'(out_req_valid), 64'd0);
        expect_rsp("bp_pop");
        tick();
        out_rsp_valid = 1'b0;
        gq.push_back(2);
        #1;
        expect_grant("bp_resume");
        tick();
        in_req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            drive_rsp(RW'(16'h0410 + k));
            #1;
            expect_rsp("bp_drain");
            tick();
        end
        out_rsp_valid = 1'b0;

        // Ordering: requests from ports 2,0,2; responses 0x11,0x22,0x33.
        in_req_data[0] = RW'(16'h0A00);
        in_req_data[2] = RW'(16'h0A02);
        in_req_valid = 3'b100; gq.push_back(2); #1; expect_grant("ord_req"); tick();
        in_req_valid = 3'b001; gq.push_back(0); #1; expect_grant("ord_req"); tick();
        in_req_valid = 3'b100; gq.push_back(2); #1; expect_grant("ord_req"); tick();
        in_req_valid = '0;
        in_rsp_ready = 3'b011;
        out_rsp_valid = 1'b1;
        out_rsp_data  = RW'(16'h0011);
        #1;
        chk("ord_head_not_ready", 64'(out_rsp_ready), 64'd0);
        chk("ord_head_valid", 64'(in_rsp_valid), 64'b100);
        tick();
        in_rsp_ready = 3'b111;
        drive_rsp(RW'(16'h0011)); #1; expect_rsp("ord_rsp1"); tick();
        drive_rsp(RW'(16'h0022)); #1; expect_rsp("ord_rsp2"); tick();
        drive_rsp(RW'(16'h0033)); #1; expect_rsp("ord_rsp3"); tick();
        out_rsp_valid = 1'b0;

        // Reset mid-transaction with two outstanding.
        for (int p = 0; p < NP; p++) in_req_data[p] = RW'(16'h100 + p);
        in_req_valid = 3'b111;
        gq.push_back(0); #1; expect_grant("mid_req"); tick();
        gq.push_back(1); #1; expect_grant("mid_req"); tick();
        rq.delete();
        rst_n = 1'b0;
        out_rsp_valid = 1'b1;
        #1;
        chk("mid_rst_out_req_valid", 64'(out_req_valid), 64'd0);
        chk("mid_rst_in_req_ready", 64'(in_req_ready), 64'd0);
        chk("mid_rst_out_rsp_ready", 64'(out_rsp_ready), 64'd0);
        chk("mid_rst_in_rsp_valid", 64'(in_rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        out_rsp_valid = 1'b0;
        #1;
        chk("post_rst_empty", 64'(out_rsp_ready), 64'd0);
        gq.push_back(0);
        expect_grant("post_rst_ptr0");
        in_req_valid = 3'b001;
        tick();
        in_req_valid = '0;
        drive_rsp(RW'(16'h0500));
        #1;
        expect_rsp("post_rst_rsp");
        tick();
        out_rsp_valid = 1'b0;

`ifdef TILE_REQ_JOIN_ISOLATE_EN
        // Isolation: one outstanding, then isolate blocks new grants until drained.
        #1;
        chk("iso_idle", 64'(isolated), 64'd0);
        in_req_valid = 3'b010; gq.push_back(1); expect_grant("iso_req"); tick();
        isolate = 1'b1;
        in_req_valid = 3'b001;
        #1;
        chk("iso_no_grant", 64'(out_req_valid), 64'd0);
        tick();
        chk("iso_outstanding", 64'(isolated), 64'd0);
        drive_rsp(RW'(16'h0600));
        #1;
        expect_rsp("iso_rsp");
        chk("iso_during_hs", 64'(isolated), 64'd0);
        tick();
        out_rsp_valid = 1'b0;
        #1;
        chk("iso_set", 64'(isolated), 64'd1);
        chk("iso_still_blocked", 64'(out_req_valid), 64'd0);
        isolate = 1'b0;
        tick();
        chk("iso_clear", 64'(isolated), 64'd0);
        chk("iso_regrant", 64'(out_req_valid), 64'd1);
        in_req_valid = '0;
        tick();
`endif

        chk("scoreboard_empty", 64'(gq.size() + rq.size() + dq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
